// File: rtl/kitchen_timer_sequencer_if.sv
// Bus between the step sequencer and its host: program port, run controls,
// timer-core command pulses and status.
interface kitchen_timer_sequencer_if #(
  parameter int IDX_W = 2
) ();
  logic             prog_we;
  logic [IDX_W-1:0] prog_addr;
  logic [1:0]       prog_data;
  logic             run;
  logic             pause;
  logic             abort;
  logic             alarm_in;
  logic             tmr_mode_1min;
  logic             tmr_mode_2min;
  logic             tmr_mode_3min;
  logic             tmr_start;
  logic             tmr_stop;
  logic [IDX_W-1:0] step_idx;
  logic             busy;
  logic             paused;
  logic             done;

  modport master (
    output prog_we, prog_addr, prog_data, run, pause, abort, alarm_in,
    input  tmr_mode_1min, tmr_mode_2min, tmr_mode_3min, tmr_start, tmr_stop,
    input  step_idx, busy, paused, done
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, run, pause, abort, alarm_in,
    output tmr_mode_1min, tmr_mode_2min, tmr_mode_3min, tmr_start, tmr_stop,
    output step_idx, busy, paused, done
  );
endinterface

// File: rtl/kitchen_timer_sequencer.sv
// Runs a short program of 1/2/3-minute countdown steps on the timer core,
// issuing mode/start/stop pulses and advancing on each alarm rising edge.
module kitchen_timer_sequencer #(
  parameter int NUM_STEPS = 4,
  parameter int IDX_W     = 2,
  parameter int SETTLE    = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  kitchen_timer_sequencer_if.slave    bus
);
  localparam int               CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int               DEPTH    = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STEPS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_START, S_RUN, S_PAUSED
  } state_t;

  state_t           state_q, state_d;
  // Storage is padded to a power of two; slots past the program depth are
  // never reached because the last-step test checks the index first.
  logic [1:0]       slot_q [DEPTH];
  logic [1:0]       slot_d [DEPTH];
  logic [IDX_W-1:0] idx_q, idx_d, nxt_idx;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             alarm_q, alarm_edge, last_step;
  logic [1:0]       mode_code;
  logic             mode1_q, mode2_q, mode3_q, start_q, stop_q, done_q, busy_q, paused_q;
  logic             mode1_d, mode2_d, mode3_d, start_d, stop_d, done_d, busy_d, paused_d;

  assign alarm_edge = bus.alarm_in & ~alarm_q;
  assign nxt_idx    = idx_q + IDX_W'(1);
  assign last_step  = (idx_q == LAST_IDX) || (slot_q[nxt_idx] == 2'b00);

  always_comb begin
    slot_d = slot_q;
    if (state_q == S_IDLE && bus.prog_we) begin
      slot_d[bus.prog_addr] = bus.prog_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    mode_code = 2'b00;
    start_d   = 1'b0;
    stop_d    = 1'b0;
    done_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // A run level still high in the done cycle must not relaunch.
        if (bus.run && !done_q) begin
          if (slot_q[0] == 2'b00) begin
            done_d = 1'b1;
          end else begin
            idx_d     = '0;
            mode_code = slot_q[0];
            state_d   = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        cnt_d   = CNT_W'(SETTLE - 1);
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          start_d = 1'b1;
          state_d = S_START;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_START: state_d = S_RUN;
      S_RUN: begin
        if (alarm_edge) begin
          if (last_step) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d     = nxt_idx;
            mode_code = slot_q[nxt_idx];
            state_d   = S_LOAD;
          end
        end else if (bus.pause) begin
          stop_d  = 1'b1;
          state_d = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (bus.run) begin
          start_d = 1'b1;
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Abort overrides every other action once a program is active.
    if (state_q != S_IDLE && bus.abort) begin
      state_d   = S_IDLE;
      idx_d     = '0;
      cnt_d     = '0;
      mode_code = 2'b00;
      start_d   = 1'b0;
      done_d    = 1'b0;
      stop_d    = 1'b1;
    end
  end

  always_comb begin
    mode1_d  = (mode_code == 2'b01);
    mode2_d  = (mode_code == 2'b10);
    mode3_d  = (mode_code == 2'b11);
    busy_d   = (state_d != S_IDLE);
    paused_d = (state_d == S_PAUSED);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      alarm_q  <= 1'b0;
      mode1_q  <= 1'b0;
      mode2_q  <= 1'b0;
      mode3_q  <= 1'b0;
      start_q  <= 1'b0;
      stop_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      paused_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= 2'b00;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      alarm_q  <= bus.alarm_in;
      mode1_q  <= mode1_d;
      mode2_q  <= mode2_d;
      mode3_q  <= mode3_d;
      start_q  <= start_d;
      stop_q   <= stop_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      paused_q <= paused_d;
      slot_q   <= slot_d;
    end
  end

  assign bus.tmr_mode_1min = mode1_q;
  assign bus.tmr_mode_2min = mode2_q;
  assign bus.tmr_mode_3min = mode3_q;
  assign bus.tmr_start     = start_q;
  assign bus.tmr_stop      = stop_q;
  assign bus.step_idx      = idx_q;
  assign bus.busy          = busy_q;
  assign bus.paused        = paused_q;
  assign bus.done          = done_q;
endmodule

// File: tb/tb_kitchen_timer_sequencer.sv
// Random program runs against a timeline model of the recipe; every pulse the
// sequencer emits is matched against a queue of predicted events.
module tb_kitchen_timer_sequencer;
  localparam int NUM_STEPS = 4;
  localparam int IDX_W     = 2;
  localparam int SETTLE    = 2;
  localparam int K_START   = 3;
  localparam int K_STOP    = 4;
  localparam int K_DONE    = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   cyc = 0;

  kitchen_timer_sequencer_if #(.IDX_W(IDX_W)) bus ();

  kitchen_timer_sequencer #(
    .NUM_STEPS(NUM_STEPS), .IDX_W(IDX_W), .SETTLE(SETTLE)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int t; int kind; int idx; bit busy; bit paused; } ev_t;
  ev_t exp_q[$];
  int  mslot[NUM_STEPS];
  int  n_checks = 0;
  int  n_pass   = 0;

  function automatic void chk(string name, int act, int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
  endfunction

  function automatic void push(int t, int kind, int idx, bit b, bit p);
    ev_t e;
    e.t = t; e.kind = kind; e.idx = idx; e.busy = b; e.paused = p;
    exp_q.push_back(e);
  endfunction

  // Monitor: any pulse on the core-control or done outputs consumes one prediction.
  int  mon_n, mon_kind;
  ev_t mon_e;
  always @(negedge clk) begin
    if (reset_n) begin
      mon_n = int'(bus.tmr_mode_1min) + int'(bus.tmr_mode_2min) + int'(bus.tmr_mode_3min)
            + int'(bus.tmr_start) + int'(bus.tmr_stop) + int'(bus.done);
      if (mon_n > 1) chk("pulse_exclusive", mon_n, 1);
      if (mon_n != 0) begin
        mon_kind = bus.tmr_mode_1min ? 0 : bus.tmr_mode_2min ? 1 : bus.tmr_mode_3min ? 2 :
                   bus.tmr_start ? K_START : bus.tmr_stop ? K_STOP : K_DONE;
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse_kind", mon_kind, -1);
        end else begin
          mon_e = exp_q.pop_front();
          $display("cycle %0d: pulse kind %0d idx %0d busy %0d paused %0d (expect t=%0d kind %0d)",
                   cyc, mon_kind, bus.step_idx, bus.busy, bus.paused, mon_e.t, mon_e.kind);
          chk("pulse_cycle", cyc, mon_e.t);
          chk("pulse_kind", mon_kind, mon_e.kind);
          chk("step_idx", int'(bus.step_idx), mon_e.idx);
          chk("busy", int'(bus.busy), int'(mon_e.busy));
          chk("paused", int'(bus.paused), int'(mon_e.paused));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(int t);
    while (cyc < t) tick();
  endtask

  task automatic write_slot(int addr, int data);
    bus.prog_we = 1'b1;
    bus.prog_addr = IDX_W'(addr);
    bus.prog_data = 2'(data);
    tick();
    bus.prog_we = 1'b0;
    mslot[addr] = data;
  endtask

  task automatic load_prog(int c0, int c1, int c2, int c3);
    write_slot(0, c0); write_slot(1, c1); write_slot(2, c2); write_slot(3, c3);
  endtask

  // Filler cycles in a busy state: program writes must be ignored.
  task automatic idle_cycles(int n, bit allow_run, bit allow_alarm);
    for (int i = 0; i < n; i++) begin
      bus.prog_we   = 1'($urandom_range(0, 1));
      bus.prog_addr = IDX_W'($urandom_range(0, NUM_STEPS - 1));
      bus.prog_data = 2'($urandom_range(0, 3));
      if (allow_run)   bus.run      = 1'($urandom_range(0, 1));
      if (allow_alarm) bus.alarm_in = 1'($urandom_range(0, 1));
      tick();
    end
    bus.prog_we = 1'b0; bus.run = 1'b0; bus.alarm_in = 1'b0;
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_mode1"}, int'(bus.tmr_mode_1min), 0);
    chk({tag, "_mode2"}, int'(bus.tmr_mode_2min), 0);
    chk({tag, "_mode3"}, int'(bus.tmr_mode_3min), 0);
    chk({tag, "_start"}, int'(bus.tmr_start), 0);
    chk({tag, "_stop"},  int'(bus.tmr_stop), 0);
    chk({tag, "_idx"},   int'(bus.step_idx), 0);
    chk({tag, "_busy"},  int'(bus.busy), 0);
    chk({tag, "_paused"}, int'(bus.paused), 0);
    chk({tag, "_done"},  int'(bus.done), 0);
  endtask

  // One program run from IDLE. Predictions come from the recipe timeline:
  // mode at t, start at t+1+SETTLE, next mode / done one cycle after an alarm edge.
  task automatic exec(int abort_step, int abort_off, int pause_step,
                      bit pause_with_alarm, bit abort_with_alarm, bit busy_write);
    int c, s, t_mode, t_start, x, a, off;
    bit fin, last;
    c = cyc;
    if (mslot[0] == 0) push(c + 1, K_DONE, 0, 1'b0, 1'b0);
    bus.run = 1'b1; tick(); bus.run = 1'b0;
    if (mslot[0] == 0) begin
      tick(); tick();
      return;
    end
    s = 0; t_mode = c + 1; fin = 1'b0;
    while (!fin) begin
      t_start = t_mode + 1 + SETTLE;
      push(t_mode, mslot[s] - 1, s, 1'b1, 1'b0);
      if (s == abort_step && !abort_with_alarm) begin
        off = (abort_off >= 0) ? abort_off : int'($urandom_range(0, SETTLE + 3));
        if (busy_write && off == 0) off = 1;
        x = t_mode + off;
        if (x >= t_start) push(t_start, K_START, s, 1'b1, 1'b0);
        push(x + 1, K_STOP, 0, 1'b0, 1'b0);
        if (busy_write) begin
          bus.prog_we = 1'b1; bus.prog_addr = IDX_W'(2); bus.prog_data = 2'b00;
          tick();
          bus.prog_we = 1'b0;
        end
        wait_until(x);
        bus.abort = 1'b1; tick(); bus.abort = 1'b0;
        tick();
        fin = 1'b1;
      end else begin
        push(t_start, K_START, s, 1'b1, 1'b0);
        wait_until(t_start + 1);
        idle_cycles($urandom_range(0, 4), 1'b1, 1'b0);
        if (s == pause_step && !pause_with_alarm) begin
          push(cyc + 1, K_STOP, s, 1'b1, 1'b1);
          bus.pause = 1'b1; tick(); bus.pause = 1'b0;
          bus.alarm_in = 1'b1; tick(); bus.alarm_in = 1'b0;
          idle_cycles($urandom_range(0, 3), 1'b0, 1'b1);
          push(cyc + 1, K_START, s, 1'b1, 1'b0);
          bus.run = 1'b1; tick(); bus.run = 1'b0;
          idle_cycles($urandom_range(0, 3), 1'b1, 1'b0);
        end
        a = cyc;
        last = (s == NUM_STEPS - 1) || (mslot[s + 1] == 0);
        if (s == abort_step && abort_with_alarm) begin
          push(a + 1, K_STOP, 0, 1'b0, 1'b0);
          bus.abort = 1'b1;
          fin = 1'b1;
        end else if (last) begin
          push(a + 1, K_DONE, 0, 1'b0, 1'b0);
          fin = 1'b1;
        end
        if (s == pause_step && pause_with_alarm) bus.pause = 1'b1;
        bus.alarm_in = 1'b1; tick();
        bus.alarm_in = 1'b0; bus.abort = 1'b0; bus.pause = 1'b0;
        if (!fin) begin
          s++;
          t_mode = a + 1;
        end else begin
          tick();
        end
      end
    end
    tick();
  endtask

  initial begin
    #(400000 * 10);
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int len, code, ab, ps;
    bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = 2'b00;
    bus.run = 1'b0; bus.pause = 1'b0; bus.abort = 1'b0; bus.alarm_in = 1'b0;
    for (int i = 0; i < NUM_STEPS; i++) mslot[i] = 0;
    #1 reset_n = 1'b0;
    #2 check_all_zero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // 3 min, 1 min, 2 min with run at cycle 10
    load_prog(3, 1, 2, 0);
    wait_until(10);
    exec(-1, -1, -1, 1'b0, 1'b0, 1'b0);

    // empty program
    load_prog(0, 0, 0, 0);
    exec(-1, -1, -1, 1'b0, 1'b0, 1'b0);

    // single 2-minute step with pause/resume
    load_prog(2, 0, 3, 1);
    exec(-1, -1, 0, 1'b0, 1'b0, 1'b0);

    // abort in SETTLE of step 1 with a write during the program, then after
    load_prog(1, 1, 1, 1);
    exec(1, 1, -1, 1'b0, 1'b0, 1'b1);
    exec(-1, -1, -1, 1'b0, 1'b0, 1'b0);
    write_slot(2, 0);
    exec(-1, -1, -1, 1'b0, 1'b0, 1'b0);

    // alarm edge beats pause; abort beats alarm edge
    load_prog(1, 3, 0, 0);
    exec(-1, -1, 0, 1'b1, 1'b0, 1'b0);
    exec(0, -1, -1, 1'b0, 1'b1, 1'b0);

    // reset in the middle of RUN
    load_prog(2, 2, 0, 0);
    push(cyc + 1, 1, 0, 1'b1, 1'b0);
    push(cyc + 2 + SETTLE, K_START, 0, 1'b1, 1'b0);
    bus.run = 1'b1; tick(); bus.run = 1'b0;
    wait_until(cyc + SETTLE + 3);
    #2 reset_n = 1'b0;
    #1 check_all_zero("midrun_reset");
    for (int i = 0; i < NUM_STEPS; i++) mslot[i] = 0;
    @(negedge clk);
    #2 reset_n = 1'b1;
    tick();
    exec(-1, -1, -1, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      len = $urandom_range(0, NUM_STEPS);
      for (int i = 0; i < NUM_STEPS; i++) begin
        if (i < len)       code = $urandom_range(1, 3);
        else if (i == len) code = 0;
        else               code = $urandom_range(0, 3);
        write_slot(i, code);
      end
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NUM_STEPS - 1)) : -1;
      ps = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NUM_STEPS - 1)) : -1;
      exec(ab, -1, ps, 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 1)));
    end

    repeat (3) tick();
    chk("outstanding_expected", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/kitchen_timer_sequencer.md
# kitchen_timer_sequencer

Multi-step program controller for the kitchen timer core. It holds a short program of up to NUM_STEPS countdown steps, each 1, 2 or 3 minutes. It drives the core's mode-select, start and stop pulses step by step and advances on each alarm. It handles pause/resume and abort, so a recipe such as "3 min, then 1 min, then 2 min" runs with one `run` command.

## Interface
- NUM_STEPS, 4, program depth (2..16)
- IDX_W, 2, width of step index, clog2(NUM_STEPS)
- SETTLE, 2, idle cycles between mode pulse and start pulse (>=1)

- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- prog_we  in  1  program write strobe
- prog_addr  in  IDX_W  program slot to write
- prog_data  in  2  step code: 00 end, 01 1 min, 10 2 min, 11 3 min
- run  in  1  start program (IDLE) / resume (PAUSED), sampled level
- pause  in  1  pause running step
- abort  in  1  cancel program
- alarm_in  in  1  alarm output of timer core
- tmr_mode_1min / tmr_mode_2min / tmr_mode_3min  out  1 each  one-cycle mode-select pulses to core
- tmr_start  out  1  one-cycle start pulse to core
- tmr_stop  out  1  one-cycle stop pulse to core
- step_idx  out  IDX_W  index of current step
- busy  out  1  high in any state except IDLE
- paused  out  1  high in PAUSED
- done  out  1  one-cycle pulse when program completes normally

## Operation
- All outputs are registered. Reset: all outputs 0, state IDLE, every program slot 00, alarm_q 0.
- Program: a write is accepted only in IDLE (prog_we=1 → slot[prog_addr]=prog_data). Writes while busy are ignored.
- alarm_q holds alarm_in delayed one cycle every cycle. Alarm edge = alarm_in & ~alarm_q.
- States: IDLE, LOAD, SETTLE, START, RUN, PAUSED.
- IDLE + run:
  - if slot[0]=00: done pulses next cycle, stay IDLE, no timer pulses.
  - otherwise: step_idx=0, go to LOAD.
- LOAD, one cycle: assert the mode pulse matching slot[step_idx], then go to SETTLE.
- SETTLE: exactly SETTLE cycles, then START.
- START, one cycle: tmr_start=1, then RUN.
- RUN + alarm edge:
  - if step_idx=NUM_STEPS-1 or slot[step_idx+1]=00: go to IDLE with a done pulse; step_idx returns to 0 with it.
  - otherwise: step_idx+1, go to LOAD.
- RUN + pause (no alarm edge): tmr_stop pulse, go to PAUSED.
- PAUSED + run: tmr_start pulse, return to RUN. Alarm edges in PAUSED are ignored.
- Any non-IDLE state + abort: tmr_stop pulse, go to IDLE, step_idx=0, no done. In IDLE, abort does nothing.
- Priority, high to low: abort > alarm edge > pause > run.
- Ignored inputs:
  - run in LOAD/SETTLE/START/RUN.
  - pause outside RUN.
- step_idx wraps only via return to 0; it never exceeds NUM_STEPS-1.

## Timing
- run sampled high in IDLE at cycle c:
  - mode pulse at c+1
  - tmr_start at c+2+SETTLE (c+4 by default)
  - busy=1 from c+1
- Alarm edge sampled at cycle a in RUN: next mode pulse, or done with busy=0, at a+1. The next start follows at a+2+SETTLE.
- pause at cycle p in RUN: tmr_stop and paused=1 at p+1.
- run at cycle r in PAUSED: tmr_start at r+1, paused=0 at r+1.
- abort at cycle x: tmr_stop at x+1, busy=0 at x+1.
- Every output pulse is exactly one cycle wide. At most one of tmr_mode_*/tmr_start/tmr_stop is high in any cycle.
- Reset asserted mid-program: all outputs go to 0 immediately (asynchronous). No stop pulse is issued.
- A level held on run/pause/abort acts once per state entry. Holding run after done does not restart the program in the same cycle that done is high.

## Test plan
- Program {11,01,10,00}, run at cycle 10, alarm edges after each start:
  - mode_3min at 11, start at 14
  - on the first alarm edge: mode_1min, then mode_2min sequence
  - done at the cycle after the third alarm edge, with step_idx=0.
- Program all slots 00, run: done at next cycle; no mode/start/stop pulse; busy stays 0.
- Program {10,00,..}: pause in RUN gives tmr_stop at +1 and paused=1. Alarm pulse while PAUSED is ignored. run gives tmr_start at +1. A later alarm edge gives done.
- Abort during SETTLE of step 1 of {01,01,01,01}: tmr_stop at +1, busy=0, no done. A write to slot 2 during the program has no effect; the same write after abort takes effect.
- Same-cycle alarm edge and pause in RUN at step 0 of {01,11,..}: mode_3min next cycle, no tmr_stop. Same-cycle abort and alarm edge: tmr_stop only.
- reset_n low mid-RUN: all outputs 0 asynchronously, slots cleared to 00. run after release gives an immediate done.
